// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle branch comparator: one SLICE_W-bit slice per cycle, MSB first, RV32 branch flags out.
// Optional build macro CMP_SEQ_EARLY_EXIT_EN finishes as soon as the first unequal slice is seen.
module cmp_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       funct3_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             eq_o,
    output logic             ne_o,
    output logic             gt_o,
    output logic             le_o,
    output logic             lt_o,
    output logic             ge_o,
    output logic             taken_o,
    output logic             illegal_o,
    output logic [1:0]       state_o
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if (WIDTH % SLICE_W != 0) begin : g_bad_slice
            $error("cmp_seq_ctrl: WIDTH must be a multiple of SLICE_W");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and a flush cancels any acceptance.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       f3_q, f3_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dec_q, dec_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             fin_q, fin_d;
    logic [7:0]       res_q, res_d;

    logic [SLICE_W-1:0] sa, sb;
    logic               slice_diff;
    logic               accept;
    logic               signed_op;
    logic               taken_c;
    logic               illegal_c;

    assign accept     = in_valid_i && (state_q == ST_IDLE) && !flush_i;
    assign signed_op  = (funct3_i == 3'b100) || (funct3_i == 3'b101);
    assign sa         = a_q[WIDTH-1 -: SLICE_W];
    assign sb         = b_q[WIDTH-1 -: SLICE_W];
    assign slice_diff = (sa != sb);
    assign illegal_c  = (f3_q[2:1] == 2'b01);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = ST_RUN;
            ST_RUN:  if (fin_q)       state_d = ST_DONE;
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_DONE);
        state_o     = state_q;
    end

    always_comb begin
        case (f3_q)
            3'b000:         taken_c = ~dec_q;
            3'b001:         taken_c = dec_q;
            3'b100, 3'b110: taken_c = lt_q;
            3'b101, 3'b111: taken_c = ~lt_q;
            default:        taken_c = 1'b0;
        endcase
    end

    // Operands are shifted left so the slice under compare is always the top SLICE_W bits.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        f3_d  = f3_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        fin_d = fin_q;
        res_d = res_q;
        if (flush_i) begin
            fin_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_d   = a_i ^ (signed_op ? MSB_MASK : '0);
                        b_d   = b_i ^ (signed_op ? MSB_MASK : '0);
                        f3_d  = funct3_i;
                        cnt_d = '0;
                        dec_d = 1'b0;
                        gt_d  = 1'b0;
                        lt_d  = 1'b0;
                        fin_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!fin_q) begin
                        if (!dec_q && slice_diff) begin
                            dec_d = 1'b1;
                            gt_d  = (sa > sb);
                            lt_d  = (sa < sb);
                        end
                        a_d   = a_q << SLICE_W;
                        b_d   = b_q << SLICE_W;
                        cnt_d = cnt_q + 1'b1;
                        fin_d = (cnt_q == LAST_CNT) || (EARLY_EXIT && !dec_q && slice_diff);
                    end else begin
                        res_d = {~dec_q, dec_q, gt_q, ~gt_q, lt_q, ~lt_q,
                                 taken_c & ~illegal_c, illegal_c};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            fin_q <= 1'b0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            f3_q  <= f3_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
            gt_q  <= gt_d;
            lt_q  <= lt_d;
            fin_q <= fin_d;
            res_q <= res_d;
        end
    end

    assign {eq_o, ne_o, gt_o, le_o, lt_o, ge_o, taken_o, illegal_o} = res_q;

endmodule
